sbox_sequencer: RTL and testbench

SBOX_SEQUENCER -- requirements
Module: sbox_sequencer

---
 rtl/sbox_seq_pkg.sv | 33 +++
 rtl/sbox_sequencer_sbox.sv | 34 +++
 rtl/sbox_sequencer.sv | 89 ++++++++
 tb/tb_sbox_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_seq_pkg.sv
// Shared types and constants for the time-multiplexed DES S-box sequencer.
// Holds the FSM state enum, block widths and the DES P-permutation table.
package sbox_seq_pkg;

    localparam int IN_W   = 48;
    localparam int OUT_W  = 32;
    localparam int SIN_W  = 6;
    localparam int SOUT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Output bit i (1 = MSB) takes input bit P_TABLE[i-1] (1 = MSB).
    localparam int P_TABLE [OUT_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [OUT_W-1:0] p_perm(input logic [OUT_W-1:0] x);
        logic [OUT_W-1:0] y;
        y = '0;
        for (int i = 0; i < OUT_W; i++) begin
            y[OUT_W-1-i] = x[OUT_W-P_TABLE[i]];
        end
        return y;
    endfunction

endpackage

// File: rtl/sbox_sequencer_sbox.sv
// Single shared DES S-box: box_num selects S1..S8, s_in is the 6-bit box input.
// Each table row is packed as 16 nibbles, column 0 in the most significant nibble.
module sbox_sequencer_sbox
    import sbox_seq_pkg::*;
(
    input  logic [SIN_W-1:0]  s_in,
    input  logic [2:0]        box_num,
    output logic [SOUT_W-1:0] s_out
);

    localparam logic [63:0] ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic [4:0]  sel;
    logic [63:0] row_word;
    logic [5:0]  nib_base;

    always_comb begin
        // Row comes from the outer bits, column from the inner four.
        sel      = {box_num, s_in[5], s_in[0]};
        row_word = ROWS[sel];
        nib_base = 6'd60 - {s_in[4:1], 2'b00};
        s_out    = row_word[nib_base +: SOUT_W];
    end

endmodule

// File: rtl/sbox_sequencer.sv
// Runs one shared S-box over all eight DES boxes, one box per clock, then holds the word.
// Build with SBOX_SEQ_PERM_EN defined to emit the P-permuted f-function output instead.
module sbox_sequencer
    import sbox_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    state_t             state, state_nxt;
    logic [2:0]         cnt;
    logic [IN_W-1:0]    hold;
    logic [OUT_W-1:0]   acc, acc_nxt, result;
    logic [SIN_W-1:0]   s_in;
    logic [SOUT_W-1:0]  s_out;

    sbox_sequencer_sbox u_sbox (
        .s_in    (s_in),
        .box_num (cnt),
        .s_out   (s_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)      state_nxt = ST_RUN;
            ST_RUN:  if (cnt == 3'd7)   state_nxt = ST_DONE;
            ST_DONE: if (out_ready)     state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);

    always_comb begin
        s_in    = hold[IN_W-1-SIN_W*int'(cnt) -: SIN_W];
        acc_nxt = acc;
        acc_nxt[OUT_W-1-SOUT_W*int'(cnt) -: SOUT_W] = s_out;
`ifdef SBOX_SEQ_PERM_EN
        result  = p_perm(acc_nxt);
`else
        result  = acc_nxt;
`endif
    end

    // cnt only advances in RUN, so its 7->0 wrap coincides with RUN->DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hold     <= '0;
            acc      <= '0;
            out_data <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        hold <= in_data;
                        cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) out_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_sequencer.sv
// Self-checking bench for sbox_sequencer: directed vectors plus random blocks
// compared against a whole-block DES S-layer model.
module tb_sbox_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    sbox_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [63:0] sbox_rows [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    function automatic logic [31:0] model_f(input logic [47:0] d);
        logic [31:0] w;
        logic [31:0] p;
        logic [5:0]  six;
        logic [63:0] rw;
        int          row, col;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            six = d[47-6*b -: 6];
            row = 2*int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            rw  = sbox_rows[4*b + row];
            w[31-4*b -: 4] = rw[63-4*col -: 4];
        end
        p = '0;
        for (int i = 0; i < 32; i++) p[31-i] = w[32-p_tab[i]];
`ifdef SBOX_SEQ_PERM_EN
        return p;
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Presents d and returns #1 after the accepting edge with in_valid dropped.
    task automatic send(input logic [47:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [31:0] exp, input int stall);
        out_ready = (stall == 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("latency_valid", 32'(out_valid), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("out_data", out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, exp);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("retire_in_ready", 32'(in_ready), 32'd1);
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_busy", 32'(busy), 32'd0);
        chk("retain_data", out_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0]  d;
        logic [31:0]  q [$];
        int           last;
        bit           acc_prev;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;

        send(48'h0);
`ifdef SBOX_SEQ_PERM_EN
        wait_done(model_f(48'h0), 0);
`else
        wait_done(32'hEFA72C4D, 0);
`endif

        send(48'h6117BA866527);
`ifdef SBOX_SEQ_PERM_EN
        wait_done(32'h234AA9BB, 20);
`else
        wait_done(32'h5C82B597, 20);
`endif

        for (int i = 0; i < 8; i++) begin
            d = rand48();
            send(d);
            wait_done(model_f(d), int'($urandom_range(0, 3)));
        end

        // abort in IDLE beats a pending capture
        @(negedge clk);
        in_valid = 1'b1; in_data = rand48(); abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);

        // abort while cnt == 4
        send(rand48());
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_run_ready", 32'(in_ready), 32'd1);
        chk("abort_run_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send(48'h0);
        wait_done(model_f(48'h0), 0);

        // async reset mid-run
        send(rand48());
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d = rand48();
        send(d);
        wait_done(model_f(d), 1);

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand48();
        last     = -1;
        acc_prev = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk);
            if (acc_prev) in_data = rand48();
            acc_prev = 1'b0;
            if (out_valid) begin
                if (q.size() > 0) chk("cont_data", out_data, q.pop_front());
                else chk("cont_unexpected_valid", 32'(out_valid), 32'd0);
            end
            if (in_ready) begin
                if (last >= 0) chk("cont_spacing", 32'(c - last), 32'd10);
                last = c;
                q.push_back(model_f(in_data));
                acc_prev = 1'b1;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid && q.size() > 0) chk("cont_drain_data", out_data, q.pop_front());
        end
        chk("cont_drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
